// File: rtl/seven_seg_scan_if.sv
// Display-driver bus: value/load from the datapath, status and pin drive back out.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4,
    parameter int IN_WIDTH   = 8
);
    logic signed [IN_WIDTH-1:0] value;
    logic                       load;
    logic                       busy;
    logic                       overflow;
    logic [6:0]                 seg;
    logic [NUM_DIGITS-1:0]      an;

    modport master (output value, load, input busy, overflow, seg, an);
    modport slave  (input value, load, output busy, overflow, seg, an);
endinterface

// File: rtl/seven_seg_scan.sv
// Signed value -> BCD (serial double-dabble) -> multiplexed common-anode 7-seg drive.
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int IN_WIDTH    = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic           clk,
    input  logic           rst,
    seven_seg_scan_if.slave bus
);
    localparam int BW = 4 * (NUM_DIGITS - 1);
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int MAX_MAG = pow10(NUM_DIGITS - 1) - 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LATCH} state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_neg;
    logic                  r_ovf_pend;
    logic [IN_WIDTH-1:0]   r_mag;
    logic [BW-1:0]         r_bcd;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_disp_bcd;
    logic                  r_disp_neg;
    logic                  r_disp_ovf;
    logic [RW-1:0]         r_ref;
    logic [IW-1:0]         r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    logic [IN_WIDTH-1:0]   w_val;
    logic [IN_WIDTH-1:0]   w_abs;
    logic                  w_abs_ovf;
    logic [BW-1:0]         w_bcd_adj;
    logic [NUM_DIGITS-1:0][6:0] w_glyph;
    logic                  w_zero_above;

    // Unsigned magnitude; the most negative input maps onto 2^(W-1), which still fits.
    assign w_val     = bus.value;
    assign w_abs     = w_val[IN_WIDTH-1] ? (~w_val + 1'b1) : w_val;
    assign w_abs_ovf = 32'(w_abs) > 32'(MAX_MAG);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS - 1; k++)
            if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_disp_bcd <= '0;
            r_disp_neg <= 1'b0;
            r_disp_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_neg      <= w_val[IN_WIDTH-1];
                        r_mag      <= w_abs;
                        r_ovf_pend <= w_abs_ovf;
                        r_bcd      <= '0;
                        r_cnt      <= CW'(IN_WIDTH);
                        r_busy     <= 1'b1;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd <= {w_bcd_adj[BW-2:0], r_mag[IN_WIDTH-1]};
                    r_mag <= {r_mag[IN_WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_disp_bcd <= r_bcd;
                    r_disp_neg <= r_neg;
                    r_disp_ovf <= r_ovf_pend;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Walk from the top magnitude digit down; blank while everything above is zero.
    always_comb begin
        w_glyph      = '1;
        w_zero_above = 1'b1;
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            if (k != 0 && w_zero_above && r_disp_bcd[4*k +: 4] == 4'd0)
                w_glyph[k] = SEG_BLANK;
            else
                w_glyph[k] = f_glyph(r_disp_bcd[4*k +: 4]);
            w_zero_above = w_zero_above && (r_disp_bcd[4*k +: 4] == 4'd0);
        end
        w_glyph[NUM_DIGITS-1] = r_disp_neg ? SEG_MINUS : SEG_BLANK;
        if (r_disp_ovf) w_glyph = {NUM_DIGITS{SEG_MINUS}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_idx <= '0;
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_glyph[r_idx];
            if (r_ref == RW'(REFRESH_DIV - 1)) begin
                r_ref <= '0;
                r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_ref <= r_ref + 1'b1;
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.overflow = r_disp_ovf;
    assign bus.seg      = r_seg;
    assign bus.an       = r_an;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench: a 4-digit and a 3-digit display driver on a shared clock/reset.
module tb_seven_seg_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(4), .IN_WIDTH(8)) bus0 ();
    seven_seg_scan_if #(.NUM_DIGITS(3), .IN_WIDTH(8)) bus1 ();

    seven_seg_scan #(.NUM_DIGITS(4), .IN_WIDTH(8), .REFRESH_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus0));
    seven_seg_scan #(.NUM_DIGITS(3), .IN_WIDTH(8), .REFRESH_DIV(4)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus1));

    localparam logic [6:0] BL = 7'b1111111, MI = 7'b0111111;
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic pulse_load(input bit sel, input logic [7:0] v);
        @(negedge clk);
        if (sel) begin bus1.value = v; bus1.load = 1'b1; end
        else     begin bus0.value = v; bus0.load = 1'b1; end
        @(negedge clk);
        bus0.load = 1'b0;
        bus1.load = 1'b0;
    endtask

    // Called right after pulse_load; counts cycles of busy, bounded.
    task automatic wait_idle(input bit sel, output int cyc);
        cyc = 0;
        while ((sel ? bus1.busy : bus0.busy) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic capture(input bit sel, output logic [3:0][6:0] d);
        logic [3:0] a;
        d = {4{7'bx}};
        @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            a = sel ? {1'b1, bus1.an} : bus0.an;
            for (int j = 0; j < 4; j++)
                if (a == ~(4'b0001 << j)) d[j] = sel ? bus1.seg : bus0.seg;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus0.an !== 4'b1111 || bus0.seg !== BL) begin
            n_fails++; $display("FAIL reset_pins4 an=%b seg=%b exp 1111/%b", bus0.an, bus0.seg, BL);
        end
        n_checks++;
        if (bus0.busy !== 1'b0 || bus0.overflow !== 1'b0) begin
            n_fails++; $display("FAIL reset_status busy=%b ovf=%b exp 0/0", bus0.busy, bus0.overflow);
        end
        n_checks++;
        if (bus1.an !== 3'b111 || bus1.seg !== BL) begin
            n_fails++; $display("FAIL reset_pins3 an=%b seg=%b exp 111/%b", bus1.an, bus1.seg, BL);
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_an  = ~(4'b0001 << (k / 4));
            exp_seg = (k / 4 == 0) ? G0 : BL;
            n_checks++;
            if (bus0.an !== exp_an || bus0.seg !== exp_seg) begin
                n_fails++;
                $display("FAIL scan_cycle%0d an=%b seg=%b exp %b/%b", k, bus0.an, bus0.seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_load_42();
        int cyc;
        logic [3:0][6:0] d, e;
        pulse_load(0, 8'sd42);
        n_checks++;
        if (bus0.busy !== 1'b1) begin n_fails++; $display("FAIL busy_rise got %b exp 1", bus0.busy); end
        wait_idle(0, cyc);
        n_checks++;
        if (cyc != 9) begin n_fails++; $display("FAIL busy_len42 got %0d exp 9", cyc); end
        capture(0, d);
        e = {BL, BL, G4, G2};
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (d[j] !== e[j]) begin n_fails++; $display("FAIL val42_dig%0d got %b exp %b", j, d[j], e[j]); end
        end
        n_checks++;
        if (bus0.overflow !== 1'b0) begin n_fails++; $display("FAIL val42_ovf got %b exp 0", bus0.overflow); end
    endtask

    task automatic test_signed_values();
        int cyc;
        logic [3:0][6:0] d;
        logic [3:0][6:0] e [3];
        logic [7:0]      v [3];
        v[0] = 8'h80; e[0] = {MI, G1, G2, G8};   // -128
        v[1] = 8'hFB; e[1] = {MI, BL, BL, G5};   // -5
        v[2] = 8'd100; e[2] = {BL, G1, G0, G0};  // inner zeros stay lit
        for (int t = 0; t < 3; t++) begin
            pulse_load(0, v[t]);
            wait_idle(0, cyc);
            n_checks++;
            if (cyc != 9) begin n_fails++; $display("FAIL busy_len_v%0d got %0d exp 9", t, cyc); end
            capture(0, d);
            for (int j = 0; j < 4; j++) begin
                n_checks++;
                if (d[j] !== e[t][j]) begin
                    n_fails++; $display("FAIL signed_v%0d_dig%0d got %b exp %b", t, j, d[j], e[t][j]);
                end
            end
        end
    endtask

    task automatic test_load_ignored();
        int cyc;
        logic [3:0][6:0] d;
        pulse_load(0, 8'sd7);
        @(negedge clk);
        @(negedge clk);
        bus0.value = 8'sd9;
        bus0.load  = 1'b1;
        @(negedge clk);
        bus0.load  = 1'b0;
        cyc = 3;
        while (bus0.busy && cyc < 40) begin @(negedge clk); cyc++; end
        n_checks++;
        if (cyc != 9) begin n_fails++; $display("FAIL busy_len_ignored got %0d exp 9", cyc); end
        capture(0, d);
        n_checks++;
        if (d[0] !== G7 || d[1] !== BL) begin
            n_fails++; $display("FAIL ignored_load got %b/%b exp %b/%b", d[0], d[1], G7, BL);
        end
        n_checks++;
        if (bus0.busy !== 1'b0) begin n_fails++; $display("FAIL ignored_restart busy=%b exp 0", bus0.busy); end
    endtask

    task automatic test_overflow();
        int cyc;
        logic [3:0][6:0] d;
        pulse_load(1, 8'sd127);
        wait_idle(1, cyc);
        capture(1, d);
        n_checks++;
        if (bus1.overflow !== 1'b1) begin n_fails++; $display("FAIL ovf127 got %b exp 1", bus1.overflow); end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (d[j] !== MI) begin n_fails++; $display("FAIL ovf127_dig%0d got %b exp %b", j, d[j], MI); end
        end
        pulse_load(1, 8'sd5);
        n_checks++;
        if (bus1.overflow !== 1'b1) begin n_fails++; $display("FAIL ovf_sticky got %b exp 1", bus1.overflow); end
        wait_idle(1, cyc);
        capture(1, d);
        n_checks++;
        if (bus1.overflow !== 1'b0 || d[0] !== G5 || d[1] !== BL || d[2] !== BL) begin
            n_fails++; $display("FAIL ovf_clear ovf=%b dig=%b/%b/%b exp 0/%b/%b/%b",
                                bus1.overflow, d[2], d[1], d[0], BL, BL, G5);
        end
        pulse_load(1, 8'sd100);
        wait_idle(1, cyc);
        n_checks++;
        if (bus1.overflow !== 1'b1) begin n_fails++; $display("FAIL ovf100 got %b exp 1", bus1.overflow); end
        pulse_load(1, 8'h9D);  // -99
        wait_idle(1, cyc);
        capture(1, d);
        n_checks++;
        if (bus1.overflow !== 1'b0 || d[0] !== G9 || d[1] !== G9 || d[2] !== MI) begin
            n_fails++; $display("FAIL neg99 ovf=%b dig=%b/%b/%b exp 0/%b/%b/%b",
                                bus1.overflow, d[2], d[1], d[0], MI, G9, G9);
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [3:0][6:0] d;
        pulse_load(0, 8'sd99);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus0.busy !== 1'b0 || bus0.an !== 4'b1111 || bus0.seg !== BL) begin
            n_fails++; $display("FAIL midrst_hold busy=%b an=%b seg=%b exp 0/1111/%b", bus0.busy, bus0.an, bus0.seg, BL);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus0.an !== 4'b1110) begin n_fails++; $display("FAIL midrst_scan got %b exp 1110", bus0.an); end
        capture(0, d);
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (d[j] !== ((j == 0) ? G0 : BL)) begin
                n_fails++; $display("FAIL midrst_dig%0d got %b exp %b", j, d[j], (j == 0) ? G0 : BL);
            end
        end
        n_checks++;
        if (bus0.busy !== 1'b0 || bus0.overflow !== 1'b0) begin
            n_fails++; $display("FAIL midrst_status busy=%b ovf=%b exp 0/0", bus0.busy, bus0.overflow);
        end
    endtask

    initial begin
        bus0.value = '0; bus0.load = 1'b0;
        bus1.value = '0; bus1.load = 1'b0;
        test_reset();
        test_load_42();
        test_signed_values();
        test_load_ignored();
        test_overflow();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
